// File: rtl/ifu_prefetch_buf.sv
// Instruction prefetch buffer: issues sequential word fetches on a req/gnt/rvalid
// bus, tracks in-flight requests and queues {pc, word} pairs for decode.
module ifu_prefetch_buf #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,

    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_addr_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_OCC   = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc_q;
    logic [31:0]      rsp_pc_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] discard_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] addr_mem [DEPTH];

    logic [31:0]      flush_pc;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W-1:0] inflight_after_rsp;
    logic             grant;
    logic             drop;
    logic             push;
    logic             pop;
    logic             unused_flush_bits;

    assign unused_flush_bits = ^flush_addr_i[1:0];

    // NOTE: every signal here is assigned unconditionally on each pass, so no latch is inferred.
    always_comb begin
        flush_pc  = {flush_addr_i[31:2], 2'b00};
        occupancy = {1'b0, count_q} + {1'b0, outstanding_q};

        // Each outstanding request owns a FIFO slot, so the response can always be pushed.
        mem_req_o = rst_ni && !flush_i
                    && (occupancy < DEPTH_OCC)
                    && (outstanding_q < MAX_OUT_CNT);
        grant     = mem_req_o && mem_gnt_i;

        drop = mem_rvalid_i && (flush_i || (discard_q != '0));
        push = mem_rvalid_i && !drop;

        instr_valid_o = (count_q != '0) && !flush_i;
        pop           = instr_valid_o && instr_ready_i;

        inflight_after_rsp = outstanding_q - CNT_W'(mem_rvalid_i);
    end

    assign mem_addr_o   = fetch_pc_q;
    assign instr_data_o = data_mem[rd_ptr_q];
    assign instr_addr_o = addr_mem[rd_ptr_q];
    assign busy_o       = (outstanding_q != '0);

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= BOOT_ADDR;
            rsp_pc_q      <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else if (flush_i) begin
            // No grant can happen here, so whatever is still in flight after this
            // cycle's response is stale and must be discarded.
            fetch_pc_q    <= flush_pc;
            rsp_pc_q      <= flush_pc;
            outstanding_q <= inflight_after_rsp;
            discard_q     <= inflight_after_rsp;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            if (grant) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            outstanding_q <= outstanding_q + CNT_W'(grant) - CNT_W'(mem_rvalid_i);

            if (drop) begin
                discard_q <= discard_q - 1'b1;
            end

            if (push) begin
                rsp_pc_q <= rsp_pc_q + 32'd4;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the entries carry no reset; count_q alone decides which of them are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_rdata_i;
            addr_mem[wr_ptr_q] <= rsp_pc_q;
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(push && (count_q == DEPTH_CNT)));

    a_no_orphan_rvalid: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(mem_rvalid_i && (outstanding_q == '0)));

    a_req_held_until_gnt: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (mem_req_o && !mem_gnt_i) |=> (flush_i || (mem_req_o && $stable(mem_addr_o))));

endmodule

// File: doc/ifu_prefetch_buf.md
Name: ifu_prefetch_buf

Overview:
- Instruction prefetch buffer between the core's decode stage and the instruction-side memory port (rom/ram peripherals).
- Issues sequential word fetches over the req/gnt/rvalid bus protocol and tracks outstanding requests.
- Buffers returned words with their addresses in a small FIFO for decode.
- On a redirect (flush), drops buffered and in-flight stale data and restarts fetching at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; also caps FIFO occupancy plus outstanding requests (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered bus requests (1..DEPTH).
- BOOT_ADDR, 32'h0000_0000, fetch PC after reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  redirect strobe, one cycle.
- flush_addr_i  in  32  redirect target; bits [1:0] ignored, forced to 0.
- instr_valid_o  out  1  FIFO head valid.
- instr_ready_i  in  1  decode accepts head.
- instr_data_o  out  32  instruction word at head.
- instr_addr_o  out  32  PC of head word.
- mem_req_o  out  1  bus request.
- mem_addr_o  out  32  bus word address (byte address, [1:0]=0).
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; responses arrive in order.
- mem_rdata_i  in  32  read data.
- busy_o  out  1  outstanding_q != 0.

Behaviour:
- **Clock and reset:** one clock domain; reset is asynchronous, active-low on rst_ni.
- **Reset values:**
  - fetch_pc_q=BOOT_ADDR, rsp_pc_q=BOOT_ADDR.
  - outstanding_q=0, discard_q=0, FIFO count=0.
  - mem_req_o=0, instr_valid_o=0, busy_o=0.
  - instr_data_o and instr_addr_o are don't-care while invalid.
- **Bus address:** mem_addr_o = fetch_pc_q.
- **Issue condition:**
  - mem_req_o = !flush_i && (count + outstanding_q < DEPTH) && (outstanding_q < MAX_OUTSTANDING).
  - Once asserted without gnt, mem_req_o and mem_addr_o hold stable until gnt; the only exception is flush_i, which drops the request that cycle.
- **Grant:** on mem_req_o && mem_gnt_i, fetch_pc_q += 4 (wraps at 2^32) and outstanding_q increments.
- **Response:**
  - On mem_rvalid_i, outstanding_q decrements (net 0 with a simultaneous grant).
  - If discard_q != 0, the word is dropped and discard_q decrements.
  - Otherwise {rsp_pc_q, mem_rdata_i} is pushed into the FIFO and rsp_pc_q += 4.
  - No same-cycle bypass: a pushed word is visible on instr_valid_o the next cycle.
- **Output and pop:**
  - instr_valid_o = (count != 0) && !flush_i.
  - Pop on instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle leave count unchanged.
  - The issue condition reserves a slot per outstanding request, so overflow is impossible. Assert: no push when full.
- **Flush (cycle where flush_i=1):**
  - FIFO cleared and no pop occurs; a concurrent instr_ready_i is not a transfer.
  - fetch_pc_q and rsp_pc_q are loaded with {flush_addr_i[31:2],2'b00}.
  - discard_q = outstanding_q − (mem_rvalid_i ? 1 : 0).
  - An rvalid in the flush cycle is dropped.
  - No request is issued that cycle.
  - Fetching resumes the next cycle.
  - A flush while discard_q != 0 recomputes discard_q with the same formula, which stays correct because outstanding_q counts all in-flight requests.
- **Latency with a zero-wait slave (gnt=req, rvalid next cycle):**
  - Cycle N: req+gnt; N+1: rvalid/push; N+2: instr_valid_o.
  - Sustains 1 instr/cycle with instr_ready_i held high.
- **Reset mid-operation:** all state returns to reset values immediately. In-flight bus responses arriving after reset release are out of contract (the slave is reset in the same domain).
- **Errors:** no error signalling on the bus; none reported.

Test Plan:
- **Boot stream:** reset release, zero-wait slave returning data=addr, instr_ready_i=1 → first instr_valid_o 2 cycles after the first req; instr_addr_o sequence 0x0,0x4,0x8…; one instruction per cycle thereafter.
- **Backpressure:** instr_ready_i=0 for 10 cycles → exactly DEPTH=4 words buffered (0x0..0xC); mem_req_o low while full. On release, words drain in order with no loss or duplication.
- **Flush with in-flight requests:** slave delays rvalid by 3 cycles with 2 outstanding; flush_i with flush_addr_i=0x103 → both stale responses dropped. The first valid instruction has instr_addr_o=0x100, and the next mem_addr_o=0x100.
- **Flush coincident with rvalid and pop:** flush_i, mem_rvalid_i and instr_ready_i all high in one cycle → FIFO empty next cycle, no transfer counted, discard_q=outstanding−1.
- **Grant stall:** mem_gnt_i held low 5 cycles → mem_req_o and mem_addr_o stable throughout; after gnt, fetch_pc advances by exactly 4.
- **Reset mid-stream and wrap:** assert rst_ni low during streaming → outputs return to reset values asynchronously. Separately, flush to 0xFFFF_FFFC → the next fetch address wraps to 0x0000_0000.
